// File: rtl/pipelined_adder_64bit_if.sv
// Operand/result handshake bundle for pipelined_adder_64bit.
// The master drives operands and out_ready; the slave (adder) returns in_ready and the result.
interface pipelined_adder_64bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        c_out;
  logic        overflow;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/pipelined_adder_64bit.sv
// Pipelined 64-bit adder: one SLICE-bit carry slice per register stage, valid/ready handshake.
// Optional macro PIPELINED_ADDER_SATURATE_EN clamps the sum on signed overflow.
module pipelined_adder_64bit #(
  parameter int SLICE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipelined_adder_64bit_if.slave bus
);
  localparam int STAGES = 64 / SLICE;

  logic stall;
  logic ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k + 1) * SLICE;
    // Operand bits still to be added by later stages.
    localparam int HI = 64 - LO;

    logic             v_src;
    logic             c_src;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   slice_sum;
    logic [LO-1:0]    s_next;
    logic [LO-1:0]    s_load;
    logic             v_q;
    logic             c_q;
    logic [LO-1:0]    s_q;

    if (k == 0) begin : g_src
      assign v_src  = bus.in_valid;
      assign c_src  = bus.c_in;
      assign a_sl   = bus.a[SLICE-1:0];
      assign b_sl   = bus.b[SLICE-1:0];
      assign s_next = slice_sum[SLICE-1:0];
    end else begin : g_src
      assign v_src  = g_stage[k-1].v_q;
      assign c_src  = g_stage[k-1].c_q;
      assign a_sl   = g_stage[k-1].g_rem.a_q[SLICE-1:0];
      assign b_sl   = g_stage[k-1].g_rem.b_q[SLICE-1:0];
      assign s_next = {slice_sum[SLICE-1:0], g_stage[k-1].s_q};
    end

    assign slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, c_src};

    if (HI > 0) begin : g_rem
      logic [HI-1:0] a_hi;
      logic [HI-1:0] b_hi;
      logic [HI-1:0] a_q;
      logic [HI-1:0] b_q;

      if (k == 0) begin : g_hi
        assign a_hi = bus.a[63:SLICE];
        assign b_hi = bus.b[63:SLICE];
      end else begin : g_hi
        assign a_hi = g_stage[k-1].g_rem.a_q[HI+SLICE-1:SLICE];
        assign b_hi = g_stage[k-1].g_rem.b_q[HI+SLICE-1:SLICE];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_hi;
          b_q <= b_hi;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic        ovf;
      logic [63:0] res;

      // The top slice of the operands holds the sign bits, so overflow and clamp are decided here.
      always_comb begin
        ovf = (a_sl[SLICE-1] == b_sl[SLICE-1]) && (s_next[63] != a_sl[SLICE-1]);
        res = s_next;
`ifdef PIPELINED_ADDER_SATURATE_EN
        if (ovf) begin
          res = a_sl[SLICE-1] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        end
`endif
      end

      assign s_load = res;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= ovf;
        end
      end
    end else begin : g_pass
      assign s_load = s_next;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_src;
        c_q <= slice_sum[SLICE];
        s_q <= s_load;
      end
    end
  end

  assign stall         = g_stage[STAGES-1].v_q && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.sum       = g_stage[STAGES-1].s_q;
  assign bus.c_out     = g_stage[STAGES-1].c_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_adder_64bit.sv
// Self-checking bench for pipelined_adder_64bit: arithmetic reference model plus scoreboard,
// with directed vectors. Honours PIPELINED_ADDER_SATURATE_EN for the clamped expectations.
module tb_pipelined_adder_64bit;
  localparam int SLICE  = 16;
  localparam int STAGES = 64 / SLICE;

`ifdef PIPELINED_ADDER_SATURATE_EN
  localparam logic [63:0] OVF_POS_SUM = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] OVF_NEG_SUM = 64'h8000_0000_0000_0000;
`else
  localparam logic [63:0] OVF_POS_SUM = 64'h8000_0000_0000_0000;
  localparam logic [63:0] OVF_NEG_SUM = 64'h0000_0000_0000_0000;
`endif

  typedef struct packed {
    logic [63:0] sum;
    logic        c_out;
    logic        ovf;
  } result_t;

  logic clk;
  logic rst_n;

  pipelined_adder_64bit_if bus ();

  pipelined_adder_64bit #(.SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int      n_checks = 0;
  int      n_pass   = 0;
  result_t exp_q[$];
  bit      stalled_prev = 0;
  result_t prev_out;
  int      run_len  = 0;
  int      last_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected result straight from the arithmetic definition of a + b + c_in.
  function automatic result_t model(input logic [63:0] x, input logic [63:0] y, input logic ci);
    logic [64:0] full;
    result_t     r;
    full    = {1'b0, x} + {1'b0, y} + {64'd0, ci};
    r.c_out = full[64];
    r.sum   = full[63:0];
    r.ovf   = (x[63] == y[63]) && (full[63] != x[63]);
`ifdef PIPELINED_ADDER_SATURATE_EN
    if (r.ovf) r.sum = x[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Called at a falling edge; holds the operands until the adder takes them.
  task automatic apply_stimulus(input logic [63:0] ta, input logic [63:0] tb_v, input logic tc);
    bit acc;
    int guard;
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb_v;
    bus.c_in     = tc;
    acc   = 0;
    guard = 0;
    do begin
      #1;
      acc = bus.in_ready && rst_n;
      @(negedge clk);
      guard++;
    end while (!acc && guard < 100);
    if (!acc) check_output("accept_timeout", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  // Called at a falling edge; returns just after it when out_valid is seen.
  task automatic wait_valid(output bit found);
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      #1;
      if (bus.out_valid) found = 1;
      else @(negedge clk);
    end
  endtask

  task automatic run_directed(input string name, input logic [63:0] ta, input logic [63:0] tb_v,
                              input logic tc, input logic [63:0] exp_sum, input logic exp_c,
                              input logic exp_ovf);
    bit found;
    apply_stimulus(ta, tb_v, tc);
    wait_valid(found);
    check_output({name, "_seen"}, 64'(found), 64'd1);
    if (found) begin
      check_output({name, "_sum"}, bus.sum, exp_sum);
      check_output({name, "_c_out"}, 64'(bus.c_out), 64'(exp_c));
      check_output({name, "_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
      @(negedge clk);
    end
  endtask

  // Scoreboard: record accepts, compare every valid output, and enforce stability during stall.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      exp_q.delete();
      stalled_prev = 0;
      run_len      = 0;
    end else begin
      if (stalled_prev) begin
        check_output("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check_output("stall_sum", bus.sum, prev_out.sum);
        check_output("stall_c_out", 64'(bus.c_out), 64'(prev_out.c_out));
        check_output("stall_ovf", 64'(bus.overflow), 64'(prev_out.ovf));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_result", 64'(bus.out_valid), 64'd0);
        end else begin
          check_output("sb_sum", bus.sum, exp_q[0].sum);
          check_output("sb_c_out", 64'(bus.c_out), 64'(exp_q[0].c_out));
          check_output("sb_ovf", 64'(bus.overflow), 64'(exp_q[0].ovf));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        run_len++;
      end else if (!bus.out_valid) begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.c_in));
      stalled_prev  = bus.out_valid && !bus.out_ready;
      prev_out.sum  = bus.sum;
      prev_out.c_out = bus.c_out;
      prev_out.ovf  = bus.overflow;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b1;

    // Model pins against hand-computed values.
    check_output("pin_basic", model(64'd5, 64'd3, 1'b1).sum, 64'd9);
    check_output("pin_wrap_c", 64'(model(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0).c_out), 64'd1);
    check_output("pin_ovf_sum", model(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0).sum, OVF_POS_SUM);

    // Reset state, including in_ready while reset is held.
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst_sum", bus.sum, 64'd0);
    check_output("rst_c_out", 64'(bus.c_out), 64'd0);
    check_output("rst_ovf", 64'(bus.overflow), 64'd0);
    check_output("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic operation with exact latency.
    apply_stimulus(64'd5, 64'd3, 1'b1);
    for (int i = 0; i < STAGES; i++) begin
      #1;
      check_output("latency_out_valid", 64'(bus.out_valid), 64'(i == STAGES - 1));
      if (i < STAGES - 1) @(negedge clk);
    end
    check_output("basic_sum", bus.sum, 64'd9);
    check_output("basic_c_out", 64'(bus.c_out), 64'd0);
    check_output("basic_ovf", 64'(bus.overflow), 64'd0);
    @(negedge clk);

    run_directed("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
    run_directed("carry_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    run_directed("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, OVF_POS_SUM, 1'b0, 1'b1);
    run_directed("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                 OVF_NEG_SUM, 1'b1, 1'b1);
    run_directed("neg_mix", 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 1'b0, 64'd3, 1'b1, 1'b0);
    repeat (STAGES + 2) @(negedge clk);

    // Back-to-back streaming of 20 random operations.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)));
    end
    repeat (STAGES + 3) @(negedge clk);
    check_output("stream_run_len", 64'(last_run), 64'd20);
    check_output("stream_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: three results pending, a fourth operand waiting while stalled.
    bus.out_ready = 1'b0;
    apply_stimulus(64'd100, 64'd200, 1'b0);
    apply_stimulus(64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b1);
    apply_stimulus(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    wait_valid(found);
    check_output("bp_seen", 64'(found), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 64'd7;
    bus.b        = 64'd8;
    bus.c_in     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    apply_stimulus(64'd7, 64'd8, 1'b0);
    repeat (2 * STAGES + 4) @(negedge clk);
    check_output("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset while three operations are in flight.
    apply_stimulus(64'd11, 64'd22, 1'b0);
    apply_stimulus(64'd33, 64'd44, 1'b0);
    apply_stimulus(64'd55, 64'd66, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("midrst_sum", bus.sum, 64'd0);
    @(negedge clk);
    for (int i = 0; i < 2 * STAGES; i++) begin
      #1;
      check_output("midrst_no_ghost", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
    end
    run_directed("after_rst", 64'd2, 64'd2, 1'b0, 64'd4, 1'b0, 1'b0);
    repeat (STAGES + 2) @(negedge clk);
    check_output("final_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
